// File: rtl/uart_tx_arb_if.sv
// Requester / transmitter bundle shared by uart_tx_arb and its users.
// UART_TX_ARB_LOCK_EN adds the req_lock vector.
interface uart_tx_arb_if #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 8
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ-1:0]              req_done;
    logic                            tx_en;
    logic [PAYLOAD_BITS-1:0]         tx_data;
    logic                            tx_done;
    logic                            busy;
    logic [OW-1:0]                   owner;
`ifdef UART_TX_ARB_LOCK_EN
    logic [NUM_REQ-1:0]              req_lock;

    modport master (
        output req_valid, req_data, tx_done, req_lock,
        input  req_ready, req_done, tx_en, tx_data, busy, owner
    );

    modport slave (
        input  req_valid, req_data, tx_done, req_lock,
        output req_ready, req_done, tx_en, tx_data, busy, owner
    );
`else
    modport master (
        output req_valid, req_data, tx_done,
        input  req_ready, req_done, tx_en, tx_data, busy, owner
    );

    modport slave (
        input  req_valid, req_data, tx_done,
        output req_ready, req_done, tx_en, tx_data, busy, owner
    );
`endif
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// UART_TX_ARB_LOCK_EN lets the current owner keep the grant via req_lock.
module uart_tx_arb #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_arb_if.slave   bus
);
    localparam int OW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [1:0]              state_q, state_d;
    logic [OW-1:0]           owner_q, owner_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic [NUM_REQ-1:0]      done_q, done_d;

    logic [OW-1:0]           cand [NUM_REQ];
    logic [PAYLOAD_BITS-1:0] bytes [NUM_REQ];
    logic [OW-1:0]           win;
    logic                    found;

    // Split the flat data bus into per-requester bytes.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            bytes[i] = bus.req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
    end

    // Round-robin pick: first valid index after the last owner, wrapping.
    always_comb begin
        win   = owner_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand[k-1] = OW'((32'(owner_q) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand[k-1]]) begin
                found = 1'b1;
                win   = cand[k-1];
            end
        end
`ifdef UART_TX_ARB_LOCK_EN
        // A locked owner with more data keeps the line for its message.
        if (bus.req_lock[owner_q] && bus.req_valid[owner_q]) begin
            found = 1'b1;
            win   = owner_q;
        end
`endif
    end

    // Next-state logic for the IDLE/ISSUE/WAIT sequence.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        data_d  = data_q;
        done_d  = '0;
        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d = win;
                    data_d  = bytes[win];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.tx_done) begin
                    done_d  = ONE << owner_q;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any byte in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            owner_q <= OW'(NUM_REQ - 1);
            data_q  <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx_en     = (state_q == S_ISSUE);
    assign bus.req_ready = (state_q == S_ISSUE) ? (ONE << owner_q) : '0;
    assign bus.req_done  = done_q;
    assign bus.tx_data   = data_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb (vector table + hand sequences).
// Build with UART_TX_ARB_LOCK_EN to exercise the lock path.
module tb_uart_tx_arb;
    localparam int N  = 4;
    localparam int PB = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arb_if #(.NUM_REQ(N), .PAYLOAD_BITS(PB)) bus ();

    uart_tx_arb #(.NUM_REQ(N), .PAYLOAD_BITS(PB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done_cyc = -1;

    typedef struct {
        logic [1:0] owner;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] dq[$];

    typedef struct {
        bit          rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  exp_owner;
        logic [7:0]  exp_data;
        int          dly;
    } vec_t;

    vec_t tv[10];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.tx_done   = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
        bus.req_lock  = '0;
`endif
        sb.delete();
        dq.delete();
        last_done_cyc = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_tx_en"}, 32'(bus.tx_en), 0);
        chk({tag, "_ready"}, 32'(bus.req_ready), 0);
        chk({tag, "_done"}, 32'(bus.req_done), 0);
        chk({tag, "_tx_data"}, 32'(bus.tx_data), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_owner"}, 32'(bus.owner), N - 1);
    endtask

    // Wait for tx_en, then compare against the scoreboard head.
    task automatic issue_check(output bit ok);
        int   lat;
        exp_t e;
        ok  = 1'b0;
        lat = 0;
        while (!ok && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.tx_en) ok = 1'b1;
        end
        if (!ok) begin
            chk("issue_timeout", 0, 1);
            return;
        end
        chk("latency", lat, 1);
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("tx_data", 32'(bus.tx_data), 32'(e.data));
        chk("req_ready", 32'(bus.req_ready), 32'(1) << e.owner);
        chk("owner", 32'(bus.owner), 32'(e.owner));
        chk("busy_issue", 32'(bus.busy), 1);
        chk("done_at_issue", 32'(bus.req_done), 0);
        if (last_done_cyc >= 0)
            chk("tx_gap", 32'((cyc - last_done_cyc) >= 2), 1);
        dq.push_back(e.owner);
    endtask

    // WAIT phase: disturb inputs, pulse tx_done, check req_done.
    task automatic finish_xfer(input int dly, input logic [7:0] exp_data);
        logic [1:0] o;
        @(negedge clk);
        chk("ready_pulse", 32'(bus.req_ready), 0);
        chk("tx_en_pulse", 32'(bus.tx_en), 0);
        chk("busy_wait", 32'(bus.busy), 1);
        bus.req_data  = ~bus.req_data;
        bus.req_valid = ~bus.req_valid;
        repeat (dly) @(negedge clk);
        chk("tx_data_hold", 32'(bus.tx_data), 32'(exp_data));
        bus.tx_done   = 1'b1;
        last_done_cyc = cyc;
        @(negedge clk);
        bus.tx_done = 1'b0;
        if (dq.size() == 0) begin
            chk("dq_empty", 0, 1);
            return;
        end
        o = dq.pop_front();
        chk("req_done", 32'(bus.req_done), 32'(1) << o);
        chk("busy_idle", 32'(bus.busy), 0);
    endtask

    initial begin
        bit ok;

        tv[0] = '{1'b1, 4'b0001, 32'h0000_0055, 2'd0, 8'h55, 3};
        tv[1] = '{1'b1, 4'b1111, 32'hA3A2_A1A0, 2'd0, 8'hA0, 1};
        tv[2] = '{1'b0, 4'b1111, 32'hA3A2_A1A0, 2'd1, 8'hA1, 0};
        tv[3] = '{1'b0, 4'b1111, 32'hA3A2_A1A0, 2'd2, 8'hA2, 2};
        tv[4] = '{1'b0, 4'b1111, 32'hA3A2_A1A0, 2'd3, 8'hA3, 1};
        tv[5] = '{1'b0, 4'b1111, 32'hA3A2_A1A0, 2'd0, 8'hA0, 0};
        tv[6] = '{1'b0, 4'b0110, 32'hA3A2_A1A0, 2'd1, 8'hA1, 1};
        tv[7] = '{1'b0, 4'b0100, 32'hA3A2_A1A0, 2'd2, 8'hA2, 4};
        tv[8] = '{1'b0, 4'b1001, 32'h1122_3344, 2'd3, 8'h11, 0};
        tv[9] = '{1'b0, 4'b1001, 32'h1122_3344, 2'd0, 8'h44, 2};

        for (int i = 0; i < 10; i++) begin
            if (tv[i].rst) begin
                do_reset();
                check_rst("reset");
            end
            bus.req_valid = tv[i].valid;
            bus.req_data  = tv[i].data;
            sb.push_back('{tv[i].exp_owner, tv[i].exp_data});
            issue_check(ok);
            if (ok) finish_xfer(tv[i].dly, tv[i].exp_data);
        end
        bus.req_valid = '0;

        // tx_done in IDLE and ISSUE must be ignored.
        do_reset();
        bus.tx_done = 1'b1;
        @(negedge clk);
        chk("idle_done_ign", 32'(bus.req_done), 0);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_owner", 32'(bus.owner), N - 1);
        bus.req_valid = 4'b0100;
        bus.req_data  = 32'hC3C2_C1C0;
        sb.push_back('{2'd2, 8'hC2});
        issue_check(ok);
        if (ok) begin
            @(negedge clk);
            bus.tx_done = 1'b0;
            chk("issue_done_busy", 32'(bus.busy), 1);
            chk("issue_done_ign", 32'(bus.req_done), 0);
            @(negedge clk);
            chk("wait_busy", 32'(bus.busy), 1);
            chk("wait_no_done", 32'(bus.req_done), 0);
            finish_xfer(1, 8'hC2);
        end
        bus.req_valid = '0;
        bus.tx_done   = 1'b0;

        // Asynchronous reset in the middle of WAIT.
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h0000_0077;
        sb.push_back('{2'd0, 8'h77});
        issue_check(ok);
        @(negedge clk);
        bus.req_valid = '0;
        #2 rst_n = 1'b0;
        #1 check_rst("async_rst");
        dq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("no_stale_done", 32'(bus.req_done), 0);
        bus.req_valid = 4'b0010;
        bus.req_data  = 32'h0000_9900;
        sb.push_back('{2'd1, 8'h99});
        issue_check(ok);
        if (ok) finish_xfer(2, 8'h99);
        bus.req_valid = '0;

        // Lock keeps requester 0 on the line; without it grants alternate.
        do_reset();
`ifdef UART_TX_ARB_LOCK_EN
        bus.req_lock = 4'b0001;
        for (int j = 0; j < 3; j++) begin
            bus.req_valid = 4'b0011;
            bus.req_data  = 32'h0000_B1B0;
            sb.push_back('{2'd0, 8'hB0});
            issue_check(ok);
            if (ok) finish_xfer(1, 8'hB0);
        end
        bus.req_lock  = 4'b0000;
        bus.req_valid = 4'b0011;
        bus.req_data  = 32'h0000_B1B0;
        sb.push_back('{2'd1, 8'hB1});
        issue_check(ok);
        if (ok) finish_xfer(1, 8'hB1);
`else
        for (int j = 0; j < 3; j++) begin
            bus.req_valid = 4'b0011;
            bus.req_data  = 32'h0000_B1B0;
            if (j == 1) sb.push_back('{2'd1, 8'hB1});
            else        sb.push_back('{2'd0, 8'hB0});
            issue_check(ok);
            if (ok) finish_xfer(1, (j == 1) ? 8'hB1 : 8'hB0);
        end
`endif
        bus.req_valid = '0;
        @(negedge clk);
        chk("end_idle", 32'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter (2..16).
REQ-002 SHALL have parameter PAYLOAD_BITS, default 8: byte width, matching the transmitter.
REQ-003 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  in  NUM_REQ: requester i has a byte pending.
REQ-006 SHALL have port req_data  in  NUM_REQ*PAYLOAD_BITS: byte of requester i in bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-007 SHALL have port req_ready  out  NUM_REQ: one-cycle pulse; byte of requester i accepted.
REQ-008 SHALL have port req_done  out  NUM_REQ: one-cycle pulse; byte of requester i fully transmitted.
REQ-009 SHALL have port tx_en  out  1: start pulse to the transmitter.
REQ-010 SHALL have port tx_data  out  PAYLOAD_BITS: byte to the transmitter.
REQ-011 SHALL have port tx_done  in  1: one-cycle end-of-stop-bit pulse from the transmitter.
REQ-012 SHALL have port busy  out  1: high in every state except IDLE.
REQ-013 SHALL have port owner  out  $clog2(NUM_REQ): index of the current or last grantee.

Function
REQ-014 SHALL implement the states IDLE, ISSUE and WAIT.
REQ-015 In IDLE with any req_valid, SHALL pick a winner by round-robin: first asserted index after owner, wrapping modulo NUM_REQ.
REQ-016 On that edge, SHALL register tx_data from the winner's req_data, load owner and go to ISSUE; with no req_valid, SHALL stay in IDLE.
REQ-017 In ISSUE, SHALL assert tx_en and req_ready[owner] for exactly one cycle, then go to WAIT.
REQ-018 Latency SHALL be one cycle from the edge sampling req_valid to the tx_en/req_ready cycle.
REQ-019 In WAIT, on tx_done, SHALL pulse req_done[owner] in the next cycle and return to IDLE.
REQ-020 The earliest next tx_en SHALL come 2 cycles after tx_done, so the transmitter is back in its idle state.
REQ-021 tx_data SHALL stay stable from ISSUE until the exit from WAIT.
REQ-022 A requester SHALL hold req_valid and req_data until its req_ready; dropping req_valid before grant SHALL be legal and lose nothing else.
REQ-023 tx_done in IDLE or ISSUE SHALL be ignored.
REQ-024 req_valid changes during ISSUE/WAIT SHALL NOT affect the transfer in flight.
REQ-025 At most one bit of req_ready and at most one bit of req_done SHALL be high in any cycle.
REQ-026 If req_valid[owner] is re-asserted with others pending, the others SHALL win first (no starvation); worst-case wait is NUM_REQ-1 bytes.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE; tx_en 0; req_ready 0; req_done 0; tx_data 0; busy 0; owner NUM_REQ-1, so index 0 wins first.
REQ-028 Reset during ISSUE or WAIT SHALL abandon the byte with no req_done; the transmitter is reset by the same rst_n.

Configuration
REQ-029 Macro UART_TX_ARB_LOCK_EN defined SHALL add input port req_lock (NUM_REQ bits).
REQ-030 With UART_TX_ARB_LOCK_EN, if req_lock[owner] is high on the IDLE arbitration edge and req_valid[owner] is high, owner SHALL win regardless of round-robin, keeping multi-byte messages contiguous.
REQ-031 Without UART_TX_ARB_LOCK_EN, req_lock SHALL be absent and arbitration SHALL be pure round-robin.

Verification
REQ-032 Reset, then req_valid=0001, req_data[7:0]=0x55 -> tx_en one cycle later with tx_data=0x55; req_ready=0001 same cycle; req_done=0001 one cycle after tx_done; owner=0.
REQ-033 req_valid=1111 held, bytes 0xA0..0xA3 -> tx order 0,1,2,3,0,...; each req_done pulse matches its owner.
REQ-034 Bench holds tx_done during ISSUE and in IDLE -> no req_done, state unaffected; tx_en gap after each tx_done >= 2 cycles.
REQ-035 rst_n asserted mid-WAIT -> all outputs at reset values asynchronously; after release, req_valid=0010 -> owner=1, no stale req_done.
REQ-036 With UART_TX_ARB_LOCK_EN: req_valid=0011, req_lock=0001 for 3 bytes -> requester 0 sends 3 consecutive bytes, then requester 1 is granted; without the macro -> grants alternate 0,1,0.
